// File: rtl/rgmii_rx_delay_cal_if.sv
// Control/status bundle between the RGMII RX delay calibrator and its surroundings.
// The master side drives requests and frame status; the slave (the calibrator) drives IDELAY taps and results.
interface rgmii_rx_delay_cal_if;
    logic       ctrl_rdy;
    logic       cal_start;
    logic       frame_ok;
    logic       frame_err;
    logic [4:0] tap_value;
    logic       tap_ld;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] best_tap;
    logic [5:0] eye_width;

    modport master (
        output ctrl_rdy, cal_start, frame_ok, frame_err,
        input  tap_value, tap_ld, busy, done, fail, best_tap, eye_width
    );

    modport slave (
        input  ctrl_rdy, cal_start, frame_ok, frame_err,
        output tap_value, tap_ld, busy, done, fail, best_tap, eye_width
    );
endinterface

// File: rtl/rgmii_rx_delay_cal.sv
// RGMII RX IDELAYE2 calibration: sweeps all 32 taps, scores each one by received frame
// quality and settles on the centre of the longest contiguous passing window.
module rgmii_rx_delay_cal #(
    parameter int FRAMES_PER_TAP = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int DEFAULT_TAP    = 0
) (
    input logic                  clk,
    input logic                  rst,
    rgmii_rx_delay_cal_if.slave  cal_if
);

    localparam int              TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]      DEF_TAP     = 5'(DEFAULT_TAP);
    localparam logic [7:0]      FRAMES      = 8'(FRAMES_PER_TAP);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_FINAL,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cur_tap_q, cur_tap_d;
    logic [7:0]      settle_cnt_q, settle_cnt_d;
    logic [7:0]      ok_cnt_q, ok_cnt_d;
    logic            err_flag_q, err_flag_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [5:0]      run_len_q, run_len_d;
    logic [4:0]      run_start_q, run_start_d;
    logic [5:0]      best_len_q, best_len_d;
    logic [4:0]      best_start_q, best_start_d;
    logic            abort_pend_q, abort_pend_d;
    logic [4:0]      tap_value_q, tap_value_d;
    logic            tap_ld_q, tap_ld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic [4:0]      best_tap_q, best_tap_d;
    logic [5:0]      eye_width_q, eye_width_d;

    logic            tap_pass;
    logic            abort_req;
    logic            go_abort;
    logic [7:0]      ok_next;
    logic            err_next;
    logic [TO_W-1:0] to_next;
    logic [5:0]      ext_len;
    logic [4:0]      ext_start;
    logic [5:0]      close_len;
    logic [4:0]      close_start;
    logic            do_close;
    logic [5:0]      sel_len;
    logic [4:0]      sel_start;
    logic [4:0]      final_tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_tap_q    <= 5'd0;
            settle_cnt_q <= 8'd0;
            ok_cnt_q     <= 8'd0;
            err_flag_q   <= 1'b0;
            to_cnt_q     <= '0;
            run_len_q    <= 6'd0;
            run_start_q  <= 5'd0;
            best_len_q   <= 6'd0;
            best_start_q <= 5'd0;
            abort_pend_q <= 1'b0;
            tap_value_q  <= DEF_TAP;
            tap_ld_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            best_tap_q   <= DEF_TAP;
            eye_width_q  <= 6'd0;
        end else begin
            state_q      <= state_d;
            cur_tap_q    <= cur_tap_d;
            settle_cnt_q <= settle_cnt_d;
            ok_cnt_q     <= ok_cnt_d;
            err_flag_q   <= err_flag_d;
            to_cnt_q     <= to_cnt_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            abort_pend_q <= abort_pend_d;
            tap_value_q  <= tap_value_d;
            tap_ld_q     <= tap_ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            best_tap_q   <= best_tap_d;
            eye_width_q  <= eye_width_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_tap_d    = cur_tap_q;
        settle_cnt_d = settle_cnt_q;
        ok_cnt_d     = ok_cnt_q;
        err_flag_d   = err_flag_q;
        to_cnt_d     = to_cnt_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        abort_pend_d = abort_pend_q;
        tap_value_d  = tap_value_q;
        tap_ld_d     = 1'b0;
        done_d       = done_q;
        fail_d       = fail_q;
        best_tap_d   = best_tap_q;
        eye_width_d  = eye_width_q;
        go_abort     = 1'b0;

        tap_pass  = (ok_cnt_q >= FRAMES) && !err_flag_q;
        abort_req = !cal_if.ctrl_rdy || abort_pend_q;
        ok_next   = (ok_cnt_q == 8'hFF) ? ok_cnt_q : ok_cnt_q + {7'd0, cal_if.frame_ok};
        err_next  = err_flag_q | cal_if.frame_err;
        to_next   = to_cnt_q + TO_ONE;

        // A pass extends the open run; a fail (or the last tap) closes whatever is open.
        ext_len   = run_len_q + 6'd1;
        ext_start = (run_len_q == 6'd0) ? cur_tap_q : run_start_q;
        if (tap_pass) begin
            close_len   = ext_len;
            close_start = ext_start;
            do_close    = (cur_tap_q == 5'd31);
        end else begin
            close_len   = run_len_q;
            close_start = run_start_q;
            do_close    = 1'b1;
        end
        if (do_close && (close_len > best_len_q)) begin
            sel_len   = close_len;
            sel_start = close_start;
        end else begin
            sel_len   = best_len_q;
            sel_start = best_start_q;
        end
        final_tap = (sel_len != 6'd0) ? sel_start + 5'((sel_len - 6'd1) >> 1) : DEF_TAP;

        case (state_q)
            ST_IDLE: begin
                if (cal_if.cal_start && cal_if.ctrl_rdy) begin
                    state_d      = ST_LOAD;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    eye_width_d  = 6'd0;
                    run_len_d    = 6'd0;
                    run_start_d  = 5'd0;
                    best_len_d   = 6'd0;
                    best_start_d = 5'd0;
                    abort_pend_d = 1'b0;
                    cur_tap_d    = 5'd0;
                    tap_value_d  = 5'd0;
                    tap_ld_d     = 1'b1;
                end
            end
            // Aborting straight out of LOAD would put two LD pulses back to back, so defer it.
            ST_LOAD: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = 8'd0;
                if (!cal_if.ctrl_rdy) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                go_abort = abort_req;
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d    = ST_MEASURE;
                    ok_cnt_d   = 8'd0;
                    err_flag_d = 1'b0;
                    to_cnt_d   = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_MEASURE: begin
                go_abort   = abort_req;
                ok_cnt_d   = ok_next;
                err_flag_d = err_next;
                to_cnt_d   = to_next;
                if ((ok_next >= FRAMES) || err_next || (to_next == TO_LIMIT)) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                go_abort     = abort_req;
                run_len_d    = (tap_pass && !do_close) ? ext_len : 6'd0;
                run_start_d  = ext_start;
                best_len_d   = sel_len;
                best_start_d = sel_start;
                tap_ld_d     = 1'b1;
                if (cur_tap_q == 5'd31) begin
                    state_d     = ST_FINAL;
                    best_tap_d  = final_tap;
                    tap_value_d = final_tap;
                    eye_width_d = sel_len;
                    fail_d      = (sel_len == 6'd0);
                end else begin
                    state_d     = ST_LOAD;
                    cur_tap_d   = cur_tap_q + 5'd1;
                    tap_value_d = cur_tap_q + 5'd1;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (go_abort) begin
            state_d      = ST_ABORT;
            abort_pend_d = 1'b0;
            tap_ld_d     = 1'b1;
            tap_value_d  = DEF_TAP;
            best_tap_d   = DEF_TAP;
            eye_width_d  = 6'd0;
            fail_d       = 1'b1;
            done_d       = 1'b1;
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ABORT);
    end

    assign cal_if.tap_value = tap_value_q;
    assign cal_if.tap_ld    = tap_ld_q;
    assign cal_if.busy      = busy_q;
    assign cal_if.done      = done_q;
    assign cal_if.fail      = fail_q;
    assign cal_if.best_tap  = best_tap_q;
    assign cal_if.eye_width = eye_width_q;

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Bench for rgmii_rx_delay_cal: a frame responder plays per-tap link quality, and a
// run-scanning model predicts the chosen tap and eye width for each sweep.
module tb_rgmii_rx_delay_cal;

    localparam int F_TAP = 4;
    localparam int S_CYC = 3;
    localparam int T_CYC = 40;
    localparam int D_TAP = 7;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rgmii_rx_delay_cal_if cal_if();

    rgmii_rx_delay_cal #(
        .FRAMES_PER_TAP (F_TAP),
        .SETTLE_CYCLES  (S_CYC),
        .TIMEOUT_CYCLES (T_CYC),
        .DEFAULT_TAP    (D_TAP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cal_if (cal_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pass_mask;
    bit          silent;
    int          both_tap;
    logic [4:0]  ld_log[$];
    int          consec_cnt;
    bit          prev_ld;

    logic [19:0] outs;
    assign outs = {cal_if.tap_value, cal_if.best_tap, cal_if.tap_ld, cal_if.busy,
                   cal_if.done, cal_if.fail, cal_if.eye_width};

    function automatic logic [19:0] exp_outs(input logic [4:0] tv, input logic [4:0] bt,
                                             input logic ld, input logic bsy, input logic dn,
                                             input logic fl, input logic [5:0] ew);
        return {tv, bt, ld, bsy, dn, fl, ew};
    endfunction

    // Reference: longest run of passing taps, lowest start wins a tie, centre rounded down.
    function automatic void model_cal(input logic [31:0] m, output logic [4:0] tap,
                                      output logic [5:0] len);
        int bl = 0;
        int bs = 0;
        int cur = 0;
        int st = 0;
        for (int i = 0; i <= 32; i++) begin
            if (i < 32 && m[i]) begin
                if (cur == 0) st = i;
                cur++;
            end else begin
                if (cur > bl) begin
                    bl = cur;
                    bs = st;
                end
                cur = 0;
            end
        end
        len = 6'(bl);
        tap = (bl > 0) ? 5'(bs + (bl - 1) / 2) : 5'(D_TAP);
    endfunction

    function automatic bit seq_ok(input logic [4:0] fin);
        if (ld_log.size() != 33) return 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (ld_log[i] != 5'(i)) return 1'b0;
        end
        return ld_log[32] == fin;
    endfunction

    function automatic logic [4:0] last_ld();
        if (ld_log.size() == 0) return 5'h1F;
        return ld_log[ld_log.size() - 1];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_ld = 1'b0;
        end else begin
            if (cal_if.tap_ld) begin
                ld_log.push_back(cal_if.tap_value);
                if (prev_ld) consec_cnt++;
            end
            prev_ld = cal_if.tap_ld;
        end
    end

    // Frame responder: follows the loaded tap and emits good or bad frames with random spacing.
    initial begin : responder
        int gap;
        int rtap;
        gap = 0;
        rtap = 0;
        cal_if.frame_ok = 1'b0;
        cal_if.frame_err = 1'b0;
        forever begin
            @(negedge clk);
            if (cal_if.tap_ld) rtap = int'(cal_if.tap_value);
            cal_if.frame_ok = 1'b0;
            cal_if.frame_err = 1'b0;
            if (gap > 0) begin
                gap--;
            end else begin
                gap = int'($urandom_range(0, 3));
                if (!silent) begin
                    if (rtap == both_tap) begin
                        cal_if.frame_ok = 1'b1;
                        cal_if.frame_err = 1'b1;
                    end else if (pass_mask[rtap]) begin
                        cal_if.frame_ok = 1'b1;
                    end else begin
                        cal_if.frame_err = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_cal(input logic [31:0] mask, input bit sil, input int both,
                           input bit poke, output bit finished);
        pass_mask = mask;
        silent = sil;
        both_tap = both;
        @(negedge clk);
        ld_log.delete();
        consec_cnt = 0;
        cal_if.cal_start = 1'b1;
        @(negedge clk);
        cal_if.cal_start = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (cal_if.done) finished = 1'b1;
            else cal_if.cal_start = poke && (cyc % 97 == 50);
        end
        cal_if.cal_start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0)) begin
            bad++;
            $display("[TB] FAIL reset_values: got %h want %h", outs,
                     exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0));
        end
        rst = 1'b0;
    endtask

    task automatic test_not_ready();
        ld_log.delete();
        cal_if.ctrl_rdy = 1'b0;
        @(negedge clk);
        cal_if.cal_start = 1'b1;
        @(negedge clk);
        cal_if.cal_start = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (ld_log.size() !== 0) begin
            bad++;
            $display("[TB] FAIL start_not_ready_ld: got %0d pulses want 0", ld_log.size());
        end
        total++;
        if (outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0)) begin
            bad++;
            $display("[TB] FAIL start_not_ready_outs: got %h want %h", outs,
                     exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0));
        end
        cal_if.ctrl_rdy = 1'b1;
    endtask

    task automatic test_known_patterns();
        logic [31:0] masks[5] = '{32'h001FFC00, 32'h00F00078, 32'hF0000000, 32'h00000000, 32'hFFFFFFFF};
        bit          sils[5]  = '{0, 0, 0, 1, 0};
        int          boths[5] = '{-1, -1, -1, -1, 5};
        logic [4:0]  etap[5]  = '{5'd15, 5'd4, 5'd29, 5'd7, 5'd18};
        logic [5:0]  elen[5]  = '{6'd11, 6'd4, 6'd4, 6'd0, 6'd26};
        bit          fin;
        for (int k = 0; k < 5; k++) begin
            run_cal(masks[k], sils[k], boths[k], 1'b0, fin);
            total++;
            if (fin !== 1'b1) begin
                bad++;
                $display("[TB] FAIL pattern%0d_done_timeout: got %b want 1", k, fin);
            end
            total++;
            if (!seq_ok(etap[k])) begin
                bad++;
                $display("[TB] FAIL pattern%0d_ld_sequence: got %0d pulses last %0d want 33 last %0d",
                         k, ld_log.size(), last_ld(), etap[k]);
            end
            total++;
            if (outs !== exp_outs(etap[k], etap[k], 0, 0, 1, elen[k] == 6'd0, elen[k])) begin
                bad++;
                $display("[TB] FAIL pattern%0d_result: got %h want %h", k, outs,
                         exp_outs(etap[k], etap[k], 0, 0, 1, elen[k] == 6'd0, elen[k]));
            end
            total++;
            if (consec_cnt !== 0) begin
                bad++;
                $display("[TB] FAIL pattern%0d_back_to_back_ld: got %0d want 0", k, consec_cnt);
            end
        end
    endtask

    task automatic test_random_masks();
        logic [31:0] m;
        logic [4:0]  et;
        logic [5:0]  el;
        bit          fin;
        for (int k = 0; k < 5; k++) begin
            m = $urandom;
            if (k == 0) m = m & 32'h0F0F0F0F;
            model_cal(m, et, el);
            run_cal(m, 1'b0, -1, 1'b0, fin);
            total++;
            if (!fin || !seq_ok(et)) begin
                bad++;
                $display("[TB] FAIL random%0d_sequence mask=%h: done=%b pulses=%0d last=%0d want last %0d",
                         k, m, fin, ld_log.size(), last_ld(), et);
            end
            total++;
            if (outs !== exp_outs(et, et, 0, 0, 1, el == 6'd0, el)) begin
                bad++;
                $display("[TB] FAIL random%0d_result mask=%h: got %h want %h", k, m, outs,
                         exp_outs(et, et, 0, 0, 1, el == 6'd0, el));
            end
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] m;
        logic [4:0]  et;
        logic [5:0]  el;
        bit          fin;
        m = $urandom;
        model_cal(m, et, el);
        run_cal(m, 1'b0, -1, 1'b1, fin);
        total++;
        if (!fin || !seq_ok(et)) begin
            bad++;
            $display("[TB] FAIL busy_start_sequence mask=%h: done=%b pulses=%0d last=%0d want 33 last %0d",
                     m, fin, ld_log.size(), last_ld(), et);
        end
        total++;
        if (outs !== exp_outs(et, et, 0, 0, 1, el == 6'd0, el)) begin
            bad++;
            $display("[TB] FAIL busy_start_result: got %h want %h", outs,
                     exp_outs(et, et, 0, 0, 1, el == 6'd0, el));
        end
    endtask

    task automatic test_abort();
        bit seen;
        pass_mask = 32'hFFFFFFFF;
        silent = 1'b0;
        both_tap = -1;
        @(negedge clk);
        ld_log.delete();
        consec_cnt = 0;
        cal_if.cal_start = 1'b1;
        @(negedge clk);
        cal_if.cal_start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (cal_if.tap_ld && cal_if.tap_value == 5'd12) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL abort_reach_tap12: got no load of 12 want one");
        end
        @(negedge clk);
        cal_if.ctrl_rdy = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 1, 0, 1, 1, 6'd0)) begin
            bad++;
            $display("[TB] FAIL abort_pulse: got %h want %h", outs,
                     exp_outs(5'(D_TAP), 5'(D_TAP), 1, 0, 1, 1, 6'd0));
        end
        cal_if.ctrl_rdy = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 1, 1, 6'd0) || consec_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL abort_after: got %h back_to_back=%0d want %h back_to_back=0", outs,
                     consec_cnt, exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 1, 1, 6'd0));
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pass_mask = $urandom;
        @(negedge clk);
        cal_if.cal_start = 1'b1;
        @(negedge clk);
        cal_if.cal_start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (cal_if.tap_ld && cal_if.tap_value == 5'd12) seen = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (!seen || outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0)) begin
            bad++;
            $display("[TB] FAIL reset_mid_async: reached12=%b got %h want %h", seen, outs,
                     exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ld_log.delete();
        repeat (20) @(negedge clk);
        total++;
        if (ld_log.size() !== 0 || outs !== exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0)) begin
            bad++;
            $display("[TB] FAIL reset_mid_no_resume: pulses=%0d got %h want 0 pulses %h", ld_log.size(),
                     outs, exp_outs(5'(D_TAP), 5'(D_TAP), 0, 0, 0, 0, 6'd0));
        end
    endtask

    task automatic test_start_after_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cal_if.cal_start = 1'b1;
        @(negedge clk);
        cal_if.cal_start = 1'b0;
        total++;
        if (outs !== exp_outs(5'd0, 5'(D_TAP), 1, 1, 0, 0, 6'd0)) begin
            bad++;
            $display("[TB] FAIL start_after_reset: got %h want %h", outs,
                     exp_outs(5'd0, 5'(D_TAP), 1, 1, 0, 0, 6'd0));
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        consec_cnt = 0;
        prev_ld = 1'b0;
        pass_mask = 32'h0;
        silent = 1'b0;
        both_tap = -1;
        cal_if.ctrl_rdy = 1'b1;
        cal_if.cal_start = 1'b0;
        test_reset();
        test_not_ready();
        test_known_patterns();
        test_random_masks();
        test_busy_start();
        test_abort();
        test_reset_mid();
        test_start_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_delay_cal.md
RGMII_RX_DELAY_CAL -- requirements
Module: rgmii_rx_delay_cal

Interface
REQ-001 Parameter FRAMES_PER_TAP, default 8: number of clean frames required for a tap to pass (1..255).
REQ-002 Parameter SETTLE_CYCLES, default 16: wait after each tap load before measuring (1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: maximum measurement window per tap.
REQ-004 Parameter DEFAULT_TAP, default 0: fallback tap (0..31).
REQ-005 Port clk, input, 1: single clock, also drives IDELAYE2 C; all logic on rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port ctrl_rdy, input, 1: IDELAYCTRL RDY, pre-synchronised to clk.
REQ-008 Port cal_start, input, 1: single-cycle calibration request.
REQ-009 Port frame_ok, input, 1: single-cycle pulse per frame received with valid preamble, SFD and FCS.
REQ-010 Port frame_err, input, 1: single-cycle pulse per frame with a preamble, SFD, FCS or rx_er error.
REQ-011 Port tap_value, output, 5: CNTVALUEIN for all RX IDELAYE2 instances (VAR_LOAD).
REQ-012 Port tap_ld, output, 1: one-cycle LD pulse.
REQ-013 Port busy, output, 1: calibration in progress.
REQ-014 Port done, output, 1: calibration finished (sticky).
REQ-015 Port fail, output, 1: no passing tap, or aborted (sticky).
REQ-016 Port best_tap, output, 5: final selected tap.
REQ-017 Port eye_width, output, 6: length of the longest passing run (0..32).

Function
REQ-018 States: IDLE, LOAD, SETTLE, MEASURE, EVAL, FINAL, DONE.
REQ-019 IDLE: accept cal_start only if ctrl_rdy=1.
  - Accept action: clear done, fail, run trackers and eye_width; set cur_tap=0; go to LOAD.
  - cal_start with ctrl_rdy=0 is ignored.
REQ-020 LOAD: drive tap_value=cur_tap and tap_ld=1 for exactly one cycle; go to SETTLE.
REQ-021 SETTLE: count SETTLE_CYCLES cycles, then clear ok_cnt, err_flag and the timeout counter; go to MEASURE.
REQ-022 MEASURE: each frame_ok increments ok_cnt (saturating at 255); any frame_err sets err_flag.
  - Exit to EVAL when ok_cnt reaches FRAMES_PER_TAP, when err_flag is set, or after TIMEOUT_CYCLES cycles.
REQ-023 frame_ok and frame_err asserted in the same cycle: both are counted and the tap fails.
REQ-024 frame_ok and frame_err are ignored outside MEASURE.
REQ-025 EVAL: tap passes iff ok_cnt>=FRAMES_PER_TAP and err_flag=0; a timeout is a fail.
REQ-026 Run tracking in EVAL:
  - A pass extends the current run (start at the first passing tap).
  - A fail closes the current run.
  - A closed run strictly longer than the best run replaces it, so on a tie the lowest-starting run is kept.
REQ-027 At cur_tap=31, a still-open run is closed and compared first; then go to FINAL. Otherwise increment cur_tap and go to LOAD. cur_tap never wraps.
REQ-028 FINAL, best length L>0:
  - best_tap = best_start + (L-1)/2, floor, 5-bit exact.
  - eye_width = L, fail = 0.
REQ-029 FINAL, L=0: best_tap = DEFAULT_TAP, eye_width = 0, fail = 1.
REQ-030 FINAL: pulse tap_ld for one cycle with tap_value = best_tap; go to DONE.
REQ-031 DONE: set done=1 and busy=0; go to IDLE the next cycle. done stays high until the next accepted cal_start.
REQ-032 busy=1 in every state except IDLE and DONE.
REQ-033 cal_start while busy is ignored.
REQ-034 ctrl_rdy falling while busy aborts:
  - Next cycle: pulse tap_ld with tap_value = DEFAULT_TAP; set best_tap = DEFAULT_TAP, fail = 1, done = 1, eye_width = 0.
  - Then go to IDLE.
REQ-035 tap_value holds its last loaded value between tap_ld pulses.
REQ-036 Only one tap_ld pulse per LOAD, FINAL or abort; never on consecutive cycles.

Reset
REQ-037 rst asserted sets the state to IDLE and all outputs to their reset values asynchronously:
  - tap_value = DEFAULT_TAP, best_tap = DEFAULT_TAP
  - tap_ld = 0, busy = 0, done = 0, fail = 0, eye_width = 0
  - all counters = 0
REQ-038 rst asserted mid-calibration: no tap_ld pulse is issued on reset, and calibration does not resume after release.
REQ-039 After rst is released, the first cal_start is accepted on the first clock edge with ctrl_rdy=1.

Verification
REQ-040 Taps 10..20 pass, all others get frame_err -> 32 tap_ld pulses with tap_value 0..31, then a final load of 15; best_tap=15, eye_width=11, done=1, fail=0.
REQ-041 Runs 3..6 and 20..23 pass, tie -> best_tap=4, eye_width=4.
REQ-042 Taps 28..31 pass (run open at end) -> best_tap=29, eye_width=4.
REQ-043 No frames ever arrive (all taps time out), DEFAULT_TAP=7 -> final tap_ld with value 7; fail=1, eye_width=0, done=1.
REQ-044 At tap 5, frame_ok and frame_err in the same cycle -> tap 5 fails. Separately, cal_start pulsed while busy -> no restart, and the tap sequence is unchanged.
REQ-045 Abort and reset mid-operation:
  - ctrl_rdy dropped at tap 12 -> next cycle tap_ld with value DEFAULT_TAP; fail=1, done=1, busy=0.
  - rst asserted at tap 12 -> all outputs return to reset values immediately.
